// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath:
// instruction fields and ALU flag in, sequencing enables and selects out.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr;
  logic [1:0] NPCOp;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic       EXTOp;
  logic       BSel;
  logic [1:0] ALUOp;
  logic       GPRSel;
  logic       WDSel;
  logic       illegal;
  logic       instr_done;
  logic [2:0] state;

  modport master (
    input  Op, Funct, Zero,
    output PCWr, NPCOp, IRWr, RFWr, DMWr, EXTOp, BSel, ALUOp,
           GPRSel, WDSel, illegal, instr_done, state
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWr, NPCOp, IRWr, RFWr, DMWr, EXTOp, BSel, ALUOp,
           GPRSel, WDSel, illegal, instr_done, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: walks each instruction through
// FETCH/DCD/EXE/MEM/WB and drives the datapath enables and selects.
module mc_ctrl #(
  parameter logic [1:0] ALU_ADD = 2'b00,
  parameter logic [1:0] ALU_SUB = 2'b01,
  parameter logic [1:0] ALU_OR  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DCD   = 3'd1;
  localparam logic [2:0] S_EXE   = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    I_ADDU = 3'd0,
    I_SUBU = 3'd1,
    I_ORI  = 3'd2,
    I_LW   = 3'd3,
    I_SW   = 3'd4,
    I_BEQ  = 3'd5,
    I_J    = 3'd6,
    I_ILL  = 3'd7
  } instr_e;

  function automatic instr_e decode(input logic [5:0] op, input logic [5:0] funct);
    instr_e c;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          c = I_ADDU;
        end else if (funct == FN_SUBU) begin
          c = I_SUBU;
        end else begin
          c = I_ILL;
        end
      end
      OP_ORI:  c = I_ORI;
      OP_LW:   c = I_LW;
      OP_SW:   c = I_SW;
      OP_BEQ:  c = I_BEQ;
      OP_J:    c = I_J;
      default: c = I_ILL;
    endcase
    return c;
  endfunction

  logic [2:0] state_q;
  logic [2:0] state_d;
  instr_e     instr_s;

  logic       pcwr_s;
  logic [1:0] npcop_s;
  logic       irwr_s;
  logic       rfwr_s;
  logic       dmwr_s;
  logic       extop_s;
  logic       bsel_s;
  logic [1:0] aluop_s;
  logic       gprsel_s;
  logic       wdsel_s;
  logic       illegal_s;
  logic       done_s;

  assign instr_s = decode(bus.Op, bus.Funct);

  // state register; the only storage in the controller
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; FETCH ignores Op/Funct since IR is still loading
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        if ((instr_s == I_J) || (instr_s == I_ILL)) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        case (instr_s)
          I_ADDU, I_SUBU, I_ORI: state_d = S_WB;
          I_LW, I_SW:            state_d = S_MEM;
          default:               state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (instr_s == I_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // per-state datapath controls, before reset gating
  always_comb begin
    pcwr_s    = 1'b0;
    npcop_s   = 2'b00;
    irwr_s    = 1'b0;
    rfwr_s    = 1'b0;
    dmwr_s    = 1'b0;
    extop_s   = 1'b0;
    bsel_s    = 1'b0;
    aluop_s   = 2'b00;
    gprsel_s  = 1'b0;
    wdsel_s   = 1'b0;
    illegal_s = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwr_s  = 1'b1;
        pcwr_s  = 1'b1;
        npcop_s = 2'b00;
      end
      S_DCD: begin
        case (instr_s)
          I_J: begin
            pcwr_s  = 1'b1;
            npcop_s = 2'b10;
            done_s  = 1'b1;
          end
          I_ILL: begin
            illegal_s = 1'b1;
            done_s    = 1'b1;
          end
          default: begin
            done_s = 1'b0;
          end
        endcase
      end
      S_EXE: begin
        case (instr_s)
          I_ADDU: aluop_s = ALU_ADD;
          I_SUBU: aluop_s = ALU_SUB;
          I_ORI: begin
            aluop_s = ALU_OR;
            bsel_s  = 1'b1;
          end
          I_LW, I_SW: begin
            aluop_s = ALU_ADD;
            bsel_s  = 1'b1;
            extop_s = 1'b1;
          end
          // branch target is relative to the PC already bumped in FETCH
          I_BEQ: begin
            aluop_s = ALU_SUB;
            extop_s = 1'b1;
            npcop_s = 2'b01;
            pcwr_s  = bus.Zero;
            done_s  = 1'b1;
          end
          default: begin
            done_s = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        if ((instr_s == I_LW) || (instr_s == I_SW)) begin
          aluop_s = ALU_ADD;
          bsel_s  = 1'b1;
          extop_s = 1'b1;
          dmwr_s  = (instr_s == I_SW);
          done_s  = (instr_s == I_SW);
        end else begin
          done_s = 1'b0;
        end
      end
      S_WB: begin
        case (instr_s)
          I_ADDU, I_SUBU: begin
            rfwr_s   = 1'b1;
            done_s   = 1'b1;
            gprsel_s = 1'b1;
            aluop_s  = (instr_s == I_SUBU) ? ALU_SUB : ALU_ADD;
          end
          I_ORI: begin
            rfwr_s  = 1'b1;
            done_s  = 1'b1;
            aluop_s = ALU_OR;
            bsel_s  = 1'b1;
          end
          I_LW: begin
            rfwr_s  = 1'b1;
            done_s  = 1'b1;
            wdsel_s = 1'b1;
          end
          default: begin
            done_s = 1'b0;
          end
        endcase
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // enables drop in the same cycle reset asserts, not at the next edge
  assign bus.PCWr       = rst & pcwr_s;
  assign bus.IRWr       = rst & irwr_s;
  assign bus.RFWr       = rst & rfwr_s;
  assign bus.DMWr       = rst & dmwr_s;
  assign bus.illegal    = rst & illegal_s;
  assign bus.instr_done = rst & done_s;
  assign bus.NPCOp      = npcop_s;
  assign bus.EXTOp      = extop_s;
  assign bus.BSel       = bsel_s;
  assign bus.ALUOp      = aluop_s;
  assign bus.GPRSel     = gprsel_s;
  assign bus.WDSel      = wdsel_s;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized instruction stream against a per-instruction trace model of
// the controller; every output is compared on every cycle.
module tb_mc_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LW = 3;
  localparam int C_SW = 4, C_BEQ = 5, C_J = 6, C_ILL = 7;

  logic [16:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs_vec();
    return {bus.state, bus.PCWr, bus.NPCOp, bus.IRWr, bus.RFWr, bus.DMWr,
            bus.EXTOp, bus.BSel, bus.ALUOp, bus.GPRSel, bus.WDSel,
            bus.illegal, bus.instr_done};
  endfunction

  // one cycle of expected outputs, fields in obs_vec order
  function automatic logic [16:0] v(input logic [2:0] st, input logic pcwr, input logic [1:0] npc,
                                    input logic irwr, input logic rfwr, input logic dmwr,
                                    input logic ext, input logic bsel, input logic [1:0] alu,
                                    input logic gpr, input logic wd, input logic ill,
                                    input logic done);
    return {st, pcwr, npc, irwr, rfwr, dmwr, ext, bsel, alu, gpr, wd, ill, done};
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h21) ? C_ADDU : ((fn == 6'h23) ? C_SUBU : C_ILL);
      6'h0D:   return C_ORI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // expected cycle-by-cycle behaviour of one instruction, FETCH first
  task automatic build_trace(input int cls, input logic z);
    exp_q.delete();
    exp_q.push_back(v(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    case (cls)
      C_J: exp_q.push_back(v(3'd1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      C_ILL: exp_q.push_back(v(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
      default: begin
        exp_q.push_back(v(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        case (cls)
          C_ADDU: begin
            exp_q.push_back(v(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(v(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
          end
          C_SUBU: begin
            exp_q.push_back(v(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(v(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1));
          end
          C_ORI: begin
            exp_q.push_back(v(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(v(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1));
          end
          C_LW: begin
            exp_q.push_back(v(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(v(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(v(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1));
          end
          C_SW: begin
            exp_q.push_back(v(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(v(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
          end
          default: begin
            exp_q.push_back(v(3'd2, z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
          end
        endcase
      end
    endcase
  endtask

  // runs one instruction; abort_at >= 0 pulls reset right after that cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int abort_at);
    int cls;
    cls = classify(op, fn);
    build_trace(cls, z);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.Op    = 6'($urandom);
        bus.Funct = 6'($urandom);
      end else begin
        bus.Op    = op;
        bus.Funct = fn;
      end
      bus.Zero = z;
      #1;
      check_eq($sformatf("op%02h_fn%02h_z%0d_cyc%0d", op, fn, z, k), 32'(obs_vec()), 32'(exp_q[k]));
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        check_eq("reset_async", 32'(obs_vec()), 32'd0);
        repeat (2) begin
          @(negedge clk);
          #1;
          check_eq("reset_hold", 32'(obs_vec()), 32'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        return;
      end
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0, 1:    return 6'h00;
      2:       return 6'h0D;
      3:       return 6'h23;
      4:       return 6'h2B;
      5:       return 6'h04;
      6:       return 6'h02;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 2))
      0:       return 6'h21;
      1:       return 6'h23;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    bus.Op    = 6'h00;
    bus.Funct = 6'h00;
    bus.Zero  = 1'b0;

    repeat (3) begin
      @(negedge clk);
      bus.Op = 6'($urandom);
      #1;
      check_eq("reset_state", 32'(obs_vec()), 32'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;

    run_instr(6'h00, 6'h21, 1'b0, -1);
    run_instr(6'h23, 6'h00, 1'b1, -1);
    run_instr(6'h2B, 6'h00, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b1, -1);
    run_instr(6'h04, 6'h00, 1'b0, -1);
    run_instr(6'h02, 6'h00, 1'b0, -1);
    run_instr(6'h3F, 6'h21, 1'b0, -1);
    run_instr(6'h00, 6'h20, 1'b0, -1);
    run_instr(6'h0D, 6'h00, 1'b0, 2);
    run_instr(6'h00, 6'h23, 1'b1, -1);

    for (int i = 0; i < 120; i++) begin
      run_instr(pick_op(), pick_fn(), 1'($urandom), ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) : -1);
    end

    @(negedge clk);
    #1;
    check_eq("final_fetch", 32'(obs_vec()),
             32'(v(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller: the producer side of the ALU operation interface.
- Sequences each instruction through FETCH/DCD/EXE/MEM/WB states.
- Drives ALUOp, operand selects and the write enables for PC, IR, register file and data memory.
- Consumes Op/Funct from the instruction register and Zero from the ALU; sits in the datapath top next to the ALU.

Parameters:
- ALU_ADD, 2'b00, ALUOp code for A+B.
- ALU_SUB, 2'b01, ALUOp code for A-B.
- ALU_OR, 2'b10, ALUOp code for A|B.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- Op  input  6  IR[31:26].
- Funct  input  6  IR[5:0].
- Zero  input  1  ALU equality flag (A==B).
- PCWr  output  1  PC write enable.
- NPCOp  output  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target.
- IRWr  output  1  IR write enable.
- RFWr  output  1  register file write enable.
- DMWr  output  1  data memory write enable.
- EXTOp  output  1  immediate extend: 0 zero-extend, 1 sign-extend.
- BSel  output  1  ALU B operand: 0 register rt, 1 extended immediate.
- ALUOp  output  2  ALU operation.
- GPRSel  output  1  write register: 0 rt, 1 rd.
- WDSel  output  1  write data: 0 ALU result, 1 memory data.
- illegal  output  1  one-cycle pulse in DCD on an unsupported Op/Funct.
- instr_done  output  1  one-cycle pulse in the last state of each instruction.
- state  output  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4.
- State register is the only storage. On rst low, state goes to FETCH immediately. While rst is low, PCWr, IRWr, RFWr, DMWr, illegal and instr_done are forced 0.
- All outputs are combinational from state, Op, Funct and Zero. Outputs not listed for a state are 0.
- Supported instructions:
  - addu: Op=000000, Funct=100001.
  - subu: Op=000000, Funct=100011.
  - ori: Op=001101.
  - lw: Op=100011.
  - sw: Op=101011.
  - beq: Op=000100.
  - j: Op=000010.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state DCD, unconditionally.
- DCD:
  - j: PCWr=1, NPCOp=10, instr_done=1; next FETCH.
  - Unsupported Op, or Op=000000 with any other Funct: illegal=1, instr_done=1; next FETCH. No state is written, so the instruction behaves as a nop.
  - All other supported instructions: next EXE.
- EXE:
  - addu: ALUOp=ALU_ADD, BSel=0; next WB.
  - subu: ALUOp=ALU_SUB, BSel=0; next WB.
  - ori: ALUOp=ALU_OR, BSel=1, EXTOp=0; next WB.
  - lw/sw: ALUOp=ALU_ADD, BSel=1, EXTOp=1; next MEM.
  - beq: ALUOp=ALU_SUB, BSel=0, EXTOp=1, NPCOp=01, PCWr=Zero, instr_done=1; next FETCH. The branch target uses the PC already incremented in FETCH.
- MEM: ALUOp, BSel and EXTOp are held at their EXE values.
  - sw: DMWr=1, instr_done=1; next FETCH.
  - lw: next WB.
- WB: RFWr=1, instr_done=1; next FETCH.
  - R-type: GPRSel=1, WDSel=0, ALUOp held.
  - ori: GPRSel=0, WDSel=0, ALUOp=ALU_OR, BSel=1.
  - lw: GPRSel=0, WDSel=1.
- CPI: j=2, beq=3, addu/subu/ori=4, sw=4, lw=5, illegal=2.
- Op/Funct are sampled only in DCD and later. Changes to them during FETCH must not affect the next state.
- Reset asserted mid-instruction: the pending write enable is dropped in the same cycle. After release, execution restarts at FETCH, and the first rising edge with rst high performs FETCH.
- Unreachable state codes 5–7: all enables 0; next FETCH.

Test Plan:
- Reset with rst=0 for 3 cycles, then release -> state=0, all enables 0 during reset; first post-release cycle has IRWr=1, PCWr=1, NPCOp=00.
- addu (Op=0, Funct=0x21) -> states 0,1,2,4,0; EXE ALUOp=00, BSel=0; WB RFWr=1, GPRSel=1, WDSel=0, instr_done=1.
- lw (Op=0x23) then sw (Op=0x2B) -> lw takes 5 cycles (WB WDSel=1, GPRSel=0); sw takes 4 cycles, with DMWr=1 only in MEM and RFWr never 1.
- beq (Op=0x04), run once with Zero=1 and once with Zero=0 -> EXE ALUOp=01, NPCOp=01; PCWr=1 with Zero=1, 0 with Zero=0; 3 cycles either way.
- j (Op=0x02), then Op=0x3F, then Op=0 with Funct=0x20 -> j: DCD PCWr=1, NPCOp=10. Illegal cases: illegal=1 for one cycle, no RFWr/DMWr/PCWr in DCD, return to FETCH.
- ori (Op=0x0D) with rst dropped during EXE -> state=0 asynchronously, RFWr never asserted; restart at FETCH after release.
